// File: rtl/secret_pkg.sv
// Shared constants and types for the secret result FIFO slice.
package secret_pkg;

    localparam int SECRET_DATA_W     = 32;
    localparam int SECRET_DEPTH      = 4;
    localparam int SECRET_DROP_CNT_W = 8;

    typedef logic [SECRET_DATA_W-1:0] secret_word_t;

endpackage

// File: rtl/secret_result_fifo_if.sv
// Stream and status bundle between the result FIFO (slave) and its producer/consumer (master).
// The checksum signal exists only when SECRET_RESULT_FIFO_CHECKSUM_EN is defined.
interface secret_result_fifo_if
    import secret_pkg::*;
#(
    parameter int DATA_W     = SECRET_DATA_W,
    parameter int DEPTH      = SECRET_DEPTH,
    parameter int DROP_CNT_W = SECRET_DROP_CNT_W
);

    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       full;
    logic                       empty;
    logic [DROP_CNT_W-1:0]      drop_cnt;
`ifdef SECRET_RESULT_FIFO_CHECKSUM_EN
    logic [DATA_W-1:0]          checksum;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, count, full, empty, drop_cnt, checksum
    );
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, count, full, empty, drop_cnt, checksum
    );
`else
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, count, full, empty, drop_cnt
    );
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, count, full, empty, drop_cnt
    );
`endif

endinterface

// File: rtl/secret_fifo_mem.sv
// DEPTH x DATA_W register-file storage: one synchronous write port, one asynchronous read port.
module secret_fifo_mem
    import secret_pkg::*;
#(
    parameter int DATA_W = SECRET_DATA_W,
    parameter int DEPTH  = SECRET_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; occupancy is tracked by pointers/count, so stale words are never exposed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/secret_result_fifo.sv
// Result buffer behind the non-stallable secret core: drops and counts words on overflow.
// Define SECRET_RESULT_FIFO_CHECKSUM_EN to add a running checksum of popped words.
module secret_result_fifo
    import secret_pkg::*;
#(
    parameter int DATA_W     = SECRET_DATA_W,
    parameter int DEPTH      = SECRET_DEPTH,
    parameter int DROP_CNT_W = SECRET_DROP_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    secret_result_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]     rd_data;

    logic empty, full;
    logic pop_req, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // pop_req frees a slot for a same-cycle push; flush cancels both the transfer and the push.
    assign pop_req = !empty && bus.out_ready;
    assign pop     = pop_req && !bus.flush;
    assign push    = bus.in_valid && (!full || pop_req) && !bus.flush;
    assign drop    = bus.in_valid && full && !pop_req && !bus.flush;

    secret_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : rd_data;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.drop_cnt  = drop_cnt_q;

`ifdef SECRET_RESULT_FIFO_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (pop) checksum_d = checksum_q + rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_secret_result_fifo.sv
// Scoreboard bench for secret_result_fifo: a queue model predicts occupancy, drops and output order.
module tb_secret_result_fifo;
    import secret_pkg::*;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4;
    localparam int DROP_CNT_W = 8;
    localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    secret_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) bus ();

    secret_result_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    secret_word_t exp_q[$];
    int           m_drop;
    secret_word_t m_csum;
    int           checks;
    int           errors;

    // One cycle: drive inputs after the falling edge, compare outputs against the model, clock, update model.
    task automatic step(input logic v, input secret_word_t d, input logic rdy, input logic fl);
        int           n;
        logic         exp_valid;
        secret_word_t exp_data;
        logic         m_pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        n         = exp_q.size();
        exp_valid = (n > 0);
        exp_data  = (n > 0) ? exp_q[0] : '0;
        checks++;
        if (bus.out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, exp_valid);
        end
        checks++;
        if (bus.out_data !== exp_data) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", bus.out_data, exp_data);
        end
        m_pop = exp_valid && rdy;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (m_pop) begin
                m_csum += exp_q[0];
                void'(exp_q.pop_front());
            end
            if (v && (n < DEPTH || m_pop)) exp_q.push_back(d);
            else if (v && m_drop < DROP_MAX) m_drop++;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drop = 0;
        m_csum = '0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++;
        if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
        rst_n = 1'b1;
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5) begin
            errors++;
            $display("FAIL first_word: got valid %b data %h expected valid 1 data 000000a5", bus.out_valid, bus.out_data);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_overflow_drain();
        secret_word_t words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int           drop_before;
        foreach (words[i]) step(1'b1, words[i], 1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 3'(exp_q.size())) begin
            errors++;
            $display("FAIL fill: got full %b count %0d expected full 1 count %0d", bus.full, bus.count, exp_q.size());
        end
        step(1'b1, 32'h55, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0);
        checks++;
        if (bus.drop_cnt !== DROP_CNT_W'(m_drop) || m_drop != 2) begin
            errors++;
            $display("FAIL overflow_drop_cnt: got %0d expected %0d", bus.drop_cnt, m_drop);
        end
        checks++;
        if (bus.out_data !== 32'h11 || bus.count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_contents: got head %h count %0d expected head 00000011 count %0d", bus.out_data, bus.count, DEPTH);
        end
        drop_before = m_drop;
        step(1'b1, 32'h77, 1'b1, 1'b0);
        checks++;
        if (bus.count !== 3'(DEPTH) || bus.drop_cnt !== DROP_CNT_W'(drop_before)) begin
            errors++;
            $display("FAIL full_push_pop: got count %0d drop %0d expected count %0d drop %0d", bus.count, bus.drop_cnt, DEPTH, drop_before);
        end
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.empty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got empty %b expected 1", bus.empty);
        end
    endtask

    task automatic test_flush();
        int drop_before;
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd3) begin errors++; $display("FAIL pre_flush_count: got %0d expected 3", bus.count); end
        drop_before = m_drop;
        step(1'b1, 32'h99, 1'b1, 1'b1);
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.drop_cnt !== DROP_CNT_W'(drop_before)) begin
            errors++;
            $display("FAIL flush: got count %0d empty %b drop %0d expected count 0 empty 1 drop %0d",
                     bus.count, bus.empty, bus.drop_cnt, drop_before);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_drop_saturation();
        repeat (DEPTH) step(1'b1, 32'hCAFE, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, secret_word_t'(i), 1'b0, 1'b0);
        checks++;
        if (bus.drop_cnt !== DROP_CNT_W'(m_drop) || m_drop != DROP_MAX) begin
            errors++;
            $display("FAIL drop_saturate: got %0d expected %0d", bus.drop_cnt, DROP_MAX);
        end
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_stream_reset();
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 32'hB2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.drop_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid %b count %0d drop %0d expected 0 0 0", bus.out_valid, bus.count, bus.drop_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap_checksum();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) step(1'b1, secret_word_t'(i), 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.empty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: got empty %b expected 1", bus.empty);
        end
`ifdef SECRET_RESULT_FIFO_CHECKSUM_EN
        checks++;
        if (bus.checksum !== m_csum || m_csum != 32'h37) begin
            errors++;
            $display("FAIL checksum: got %h expected %h", bus.checksum, m_csum);
        end
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bus.checksum !== m_csum) begin
            errors++;
            $display("FAIL checksum_flush: got %h expected %h", bus.checksum, m_csum);
        end
`endif
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        model_reset();
        @(negedge clk);

        test_reset();
        test_fill_overflow_drain();
        test_flush();
        test_drop_saturation();
        test_mid_stream_reset();
        test_wrap_checksum();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
